// File: rtl/blit_if.sv
// Command and RAM port-b bundle shared by the blit engine and its environment.
//
// Handshake: a command transfers on every rising clk edge where cmd_valid and
// cmd_ready are both high. A RAM request (read_b or write_b) holds its strobe,
// x_b, y_b and in_b until the cycle rdy_b is high, then drops the strobe in the
// following cycle. An rdy_b with no request outstanding carries no meaning.
interface blit_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [8:0] src_x;
   logic [7:0] src_y;
   logic [8:0] dst_x;
   logic [7:0] dst_y;
   logic [8:0] w;
   logic [7:0] h;
   logic       color;
   logic       busy;
   logic       done;
   logic [8:0] x_b;
   logic [7:0] y_b;
   logic       read_b;
   logic       write_b;
   logic       in_b;
   logic       out_b;
   logic       rdy_b;

   // Register block and RAM side: issues commands, answers RAM requests.
   modport master (
      output cmd_valid, cmd_op, src_x, src_y, dst_x, dst_y, w, h, color,
      output out_b, rdy_b,
      input  cmd_ready, busy, done, x_b, y_b, read_b, write_b, in_b
   );

   // Engine side.
   modport slave (
      input  cmd_valid, cmd_op, src_x, src_y, dst_x, dst_y, w, h, color,
      input  out_b, rdy_b,
      output cmd_ready, busy, done, x_b, y_b, read_b, write_b, in_b
   );
endinterface

// File: rtl/blit_engine.sv
// 1-bpp rectangle blitter: FILL, COPY and INVERT over a WIDTH x HEIGHT
// framebuffer reached through a single request/acknowledge RAM port.
// Pixels are walked row-major; off-screen pixels cost one NEXT cycle each.
module blit_engine #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 200
) (
   input  logic       clk,
   input  logic       rst,
   blit_if.slave      bus,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_NEXT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
   localparam logic [8:0] HEIGHT_L = 9'(HEIGHT);
   localparam logic [1:0] OP_FILL  = 2'b00;
   localparam logic [1:0] OP_COPY  = 2'b01;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [8:0] src_x_q, src_x_d;
   logic [7:0] src_y_q, src_y_d;
   logic [8:0] dst_x_q, dst_x_d;
   logic [7:0] dst_y_q, dst_y_d;
   logic [8:0] w_q, w_d;
   logic [7:0] h_q, h_d;
   logic       color_q, color_d;
   logic [8:0] i_q, i_d;
   logic [7:0] j_q, j_d;
   logic       data_q, data_d;

   // Sums are widened by one bit so a corner near the edge plus an offset
   // lands off-screen instead of wrapping back onto it.
   function automatic logic on_screen(input logic [8:0] bx, input logic [7:0] by,
                                      input logic [8:0] ox, input logic [7:0] oy);
      logic [9:0] sx;
      logic [8:0] sy;
      sx = {1'b0, bx} + {1'b0, ox};
      sy = {1'b0, by} + {1'b0, oy};
      return (sx < WIDTH_L) && (sy < HEIGHT_L);
   endfunction

   // Where pixel (i, j) starts: skipped pixels go through NEXT only.
   function automatic state_t pixel_entry(input logic [1:0] op,
                                          input logic [8:0] sx, input logic [7:0] sy,
                                          input logic [8:0] dx, input logic [7:0] dy,
                                          input logic [8:0] i, input logic [7:0] j);
      if (!on_screen(dx, dy, i, j))
         return S_NEXT;
      if ((op == OP_COPY) && !on_screen(sx, sy, i, j))
         return S_NEXT;
      if (op == OP_FILL)
         return S_WR;
      return S_RD;
   endfunction

   // State and command registers; reset drops any in-flight request at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         src_x_q <= '0;
         src_y_q <= '0;
         dst_x_q <= '0;
         dst_y_q <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= 1'b0;
         i_q     <= '0;
         j_q     <= '0;
         data_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src_x_q <= src_x_d;
         src_y_q <= src_y_d;
         dst_x_q <= dst_x_d;
         dst_y_q <= dst_y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         color_q <= color_d;
         i_q     <= i_d;
         j_q     <= j_d;
         data_q  <= data_d;
      end
   end

   // Next-state: accept in IDLE, wait for rdy_b in RD/WR, walk pixels in NEXT.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      src_x_d = src_x_q;
      src_y_d = src_y_q;
      dst_x_d = dst_x_q;
      dst_y_d = dst_y_q;
      w_d     = w_q;
      h_d     = h_q;
      color_d = color_q;
      i_d     = i_q;
      j_d     = j_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               src_x_d = bus.src_x;
               src_y_d = bus.src_y;
               dst_x_d = bus.dst_x;
               dst_y_d = bus.dst_y;
               w_d     = bus.w;
               h_d     = bus.h;
               color_d = bus.color;
               i_d     = '0;
               j_d     = '0;
               if ((bus.w == 9'd0) || (bus.h == 8'd0) || (bus.cmd_op == OP_RSVD))
                  state_d = S_DONE;
               else
                  state_d = pixel_entry(bus.cmd_op, bus.src_x, bus.src_y,
                                        bus.dst_x, bus.dst_y, 9'd0, 8'd0);
            end
         end
         S_RD: begin
            if (bus.rdy_b) begin
               data_d  = bus.out_b;
               state_d = S_WR;
            end
         end
         S_WR: begin
            if (bus.rdy_b)
               state_d = S_NEXT;
         end
         S_NEXT: begin
            if (i_q == w_q - 9'd1) begin
               i_d = '0;
               if (j_q == h_q - 8'd1) begin
                  state_d = S_DONE;
               end else begin
                  j_d     = j_q + 8'd1;
                  state_d = pixel_entry(op_q, src_x_q, src_y_q, dst_x_q, dst_y_q,
                                        9'd0, j_q + 8'd1);
               end
            end else begin
               i_d     = i_q + 9'd1;
               state_d = pixel_entry(op_q, src_x_q, src_y_q, dst_x_q, dst_y_q,
                                     i_q + 9'd1, j_q);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   logic       rd_req;
   logic       wr_req;
   logic [8:0] addr_x;
   logic [7:0] addr_y;
   logic       wr_data;

   // Request address and data: COPY reads from the source, all else hits the
   // destination. Outputs are forced low when no request is outstanding.
   always_comb begin
      rd_req  = (state_q == S_RD);
      wr_req  = (state_q == S_WR);
      addr_x  = dst_x_q + i_q;
      addr_y  = dst_y_q + j_q;
      if (rd_req && (op_q == OP_COPY)) begin
         addr_x = src_x_q + i_q;
         addr_y = src_y_q + j_q;
      end
      case (op_q)
         OP_FILL: wr_data = color_q;
         OP_COPY: wr_data = data_q;
         default: wr_data = ~data_q;
      endcase
   end

   assign bus.read_b    = rd_req;
   assign bus.write_b   = wr_req;
   assign bus.x_b       = (rd_req || wr_req) ? addr_x : 9'd0;
   assign bus.y_b       = (rd_req || wr_req) ? addr_y : 8'd0;
   assign bus.in_b      = wr_req ? wr_data : 1'b0;
   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_blit_engine.sv
// Directed bench for blit_engine: a behavioural framebuffer answers RAM
// requests and a reference walk of each command fills the expected queue.
module tb_blit_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;

   blit_if bus ();

   blit_engine #(.WIDTH(320), .HEIGHT(200)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // Clock: 10 time units, inputs driven and outputs sampled on the falling edge.
   always #5 clk = ~clk;

   int          compared_cnt = 0;
   int          mismatch_cnt = 0;
   logic [18:0] exp_q[$];
   logic        ram     [0:319][0:199];
   logic        ref_mem [0:319][0:199];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared_cnt++;
      assert (obs === exp) else begin
         mismatch_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit visible(input int x, input int y);
      return (x < 320) && (y < 200);
   endfunction

   task automatic push_req(input bit wr, input int x, input int y, input logic d);
      exp_q.push_back({wr, 9'(x), 8'(y), d});
   endtask

   // Reference walk: row-major, skipping off-screen pixels, applying each write
   // to ref_mem as it goes so later reads see earlier writes.
   task automatic build_expect(input logic [1:0] op, input int sx, input int sy,
                               input int dx, input int dy, input int w, input int h,
                               input logic color);
      int   tx, ty, fx, fy;
      logic v;
      if (op == 2'b11) return;
      for (int j = 0; j < h; j++) begin
         for (int i = 0; i < w; i++) begin
            tx = dx + i; ty = dy + j; fx = sx + i; fy = sy + j;
            if (!visible(tx, ty)) continue;
            if (op == 2'b01 && !visible(fx, fy)) continue;
            if (op == 2'b00) begin
               push_req(1'b1, tx, ty, color);
               ref_mem[tx][ty] = color;
            end else if (op == 2'b01) begin
               v = ref_mem[fx][fy];
               push_req(1'b0, fx, fy, 1'b0);
               push_req(1'b1, tx, ty, v);
               ref_mem[tx][ty] = v;
            end else begin
               v = ~ref_mem[tx][ty];
               push_req(1'b0, tx, ty, 1'b0);
               push_req(1'b1, tx, ty, v);
               ref_mem[tx][ty] = v;
            end
         end
      end
   endtask

   // Issue one command, act as the RAM with 'lat' wait cycles per request,
   // and score every completed request against the expected queue.
   task automatic run_cmd(input logic [1:0] op, input logic [8:0] sx, input logic [7:0] sy,
                          input logic [8:0] dx, input logic [7:0] dy,
                          input logic [8:0] w, input logic [7:0] h, input logic color,
                          input int lat, input bit poke,
                          output int first_req_k, output int done_k);
      int          k, seen;
      bit          got_done;
      logic [18:0] obs, first_obs, e;
      build_expect(op, int'(sx), int'(sy), int'(dx), int'(dy), int'(w), int'(h), color);
      @(negedge clk);
      check("ready_before_cmd", bus.cmd_ready, 1);
      bus.cmd_op = op; bus.src_x = sx; bus.src_y = sy; bus.dst_x = dx; bus.dst_y = dy;
      bus.w = w; bus.h = h; bus.color = color; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      k = 1; seen = 0; got_done = 1'b0; first_req_k = -1; done_k = -1; first_obs = '0;
      while (!got_done && k < 3000) begin
         if (k == 1) check("busy_after_accept", bus.busy, 1);
         if (poke && k == 3) begin
            check("ready_while_busy", bus.cmd_ready, 0);
            bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.dst_x = 9'd3; bus.dst_y = 8'd3;
            bus.src_x = 9'd9; bus.w = 9'd1; bus.h = 8'd1; bus.color = ~color;
         end
         if (poke && k == 4) bus.cmd_valid = 1'b0;
         if (bus.rdy_b) begin
            bus.rdy_b = 1'b0;
            seen = 0;
         end
         if (bus.read_b || bus.write_b) begin
            if (first_req_k < 0) first_req_k = k;
            check("strobes_exclusive", {bus.read_b, bus.write_b} != 2'b11, 1);
            obs = {bus.write_b, bus.x_b, bus.y_b, bus.write_b ? bus.in_b : 1'b0};
            if (seen == 0) first_obs = obs;
            else check("req_stable", obs, first_obs);
            if (seen == lat) begin
               bus.rdy_b = 1'b1;
               if (bus.x_b < 9'd320 && bus.y_b < 8'd200) begin
                  if (bus.read_b) bus.out_b = ram[bus.x_b][bus.y_b];
                  else ram[bus.x_b][bus.y_b] = bus.in_b;
               end
               compared_cnt++;
               assert (exp_q.size() > 0) else begin
                  mismatch_cnt++;
                  $error("FAIL req_extra observed=%0h expected=none", obs);
               end
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("req", obs, e);
               end
            end
            seen++;
         end
         if (bus.done) begin
            got_done = 1'b1;
            done_k = k;
         end else begin
            @(negedge clk);
            k++;
         end
      end
      check("done_seen", got_done, 1);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      bus.rdy_b = 1'b0;
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("ready_after_done", bus.cmd_ready, 1);
      check("busy_after_done", bus.busy, 0);
   endtask

   int   frk, dk;
   bit   any_done;

   initial begin
      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.src_x = '0; bus.src_y = '0;
      bus.dst_x = '0; bus.dst_y = '0; bus.w = '0; bus.h = '0; bus.color = 1'b0;
      bus.out_b = 1'b0; bus.rdy_b = 1'b0;
      for (int x = 0; x < 320; x++)
         for (int y = 0; y < 200; y++) begin
            ram[x][y]     = 1'($urandom_range(0, 1));
            ref_mem[x][y] = ram[x][y];
         end

      // Reset values, checked before any clock edge.
      #2;
      check("rst_read_b", bus.read_b, 0);
      check("rst_write_b", bus.write_b, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_x_b", bus.x_b, 0);
      check("rst_y_b", bus.y_b, 0);
      check("rst_in_b", bus.in_b, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // FILL 3x2 at (10,5): six writes, first one the cycle after acceptance.
      run_cmd(2'b00, 9'd0, 8'd0, 9'd10, 8'd5, 9'd3, 8'd2, 1'b1, 1, 1'b0, frk, dk);
      check("fill_first_req_cycle", frk, 1);
      check("fill_pixel_12_6", ram[12][6], 1);

      // COPY 2x1 from (0,0) to (100,50) with known source bits.
      ram[0][0] = 1'b1; ref_mem[0][0] = 1'b1;
      ram[1][0] = 1'b0; ref_mem[1][0] = 1'b0;
      run_cmd(2'b01, 9'd0, 8'd0, 9'd100, 8'd50, 9'd2, 8'd1, 1'b0, 1, 1'b0, frk, dk);
      check("copy_dst_100_50", ram[100][50], 1);
      check("copy_dst_101_50", ram[101][50], 0);

      // INVERT clipped at the bottom-right corner: only two pixels visible.
      run_cmd(2'b10, 9'd0, 8'd0, 9'd318, 8'd199, 9'd4, 8'd2, 1'b0, 2, 1'b0, frk, dk);

      // Zero-size commands: done one cycle after acceptance, no strobes.
      run_cmd(2'b00, 9'd0, 8'd0, 9'd20, 8'd20, 9'd0, 8'd3, 1'b1, 1, 1'b0, frk, dk);
      check("w0_done_latency", dk, 1);
      check("w0_no_req", frk, -1);
      run_cmd(2'b01, 9'd1, 8'd1, 9'd20, 8'd20, 9'd3, 8'd0, 1'b1, 1, 1'b0, frk, dk);
      check("h0_done_latency", dk, 1);
      run_cmd(2'b11, 9'd1, 8'd1, 9'd20, 8'd20, 9'd3, 8'd3, 1'b1, 1, 1'b0, frk, dk);
      check("rsvd_done_latency", dk, 1);
      check("rsvd_no_req", frk, -1);

      // Stalled acknowledge with a command poke and field changes while busy.
      run_cmd(2'b00, 9'd0, 8'd0, 9'd30, 8'd40, 9'd2, 8'd1, 1'b0, 5, 1'b1, frk, dk);

      // COPY whose source runs off the right edge; random RAM latency.
      run_cmd(2'b01, 9'd318, 8'd10, 9'd0, 8'd100, 9'd4, 8'd2, 1'b0,
              int'($urandom_range(1, 3)), 1'b0, frk, dk);
      run_cmd(2'b10, 9'd50, 8'd60, 9'd50, 8'd60, 9'd3, 8'd3, 1'b0,
              int'($urandom_range(1, 3)), 1'b0, frk, dk);

      // Reset mid-FILL while write_b is high.
      @(negedge clk);
      bus.cmd_op = 2'b00; bus.dst_x = 9'd20; bus.dst_y = 8'd20; bus.w = 9'd4;
      bus.h = 8'd1; bus.color = 1'b1; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("abort_write_active", bus.write_b, 1);
      #1 rst = 1'b1;
      #1;
      check("abort_write_b", bus.write_b, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_ready", bus.cmd_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      any_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.done) any_done = 1'b1;
      end
      check("abort_no_done", any_done, 0);
      run_cmd(2'b00, 9'd0, 8'd0, 9'd5, 8'd5, 9'd2, 8'd1, 1'b1, 1, 1'b0, frk, dk);
      check("post_reset_first_req", frk, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
      $finish;
   end

endmodule
